// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - EX pipeline stage: ALU, branch-target adder, destination mux and EX/MEM latch
// Optional feature: define EX_OVF_TRAP_EN to trap signed overflow on R-type add/sub.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  ctlwb_in,
  input  logic [2:0]  ctlm_in,
  input  logic        regdst,
  input  logic [1:0]  aluop,
  input  logic        alusrc,
  input  logic [31:0] npc,
  input  logic [31:0] rdata1,
  input  logic [31:0] rdata2,
  input  logic [31:0] s_extendout,
  input  logic [5:0]  funct,
  input  logic [4:0]  instr_2016,
  input  logic [4:0]  instr_1511,
  output logic [1:0]  mem_ctlwb_out,
  output logic [2:0]  mem_ctlm_out,
  output logic [31:0] add_result,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] rdata2out,
  output logic [4:0]  muxout,
  output logic        ovf
);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic [31:0] alu_b, sum, diff, alu_res;
  logic        slt_bit, ovf_trap;

  assign alu_b   = alusrc ? s_extendout : rdata2;
  assign sum     = rdata1 + alu_b;
  assign diff    = rdata1 - alu_b;
  assign slt_bit = $signed(rdata1) < $signed(alu_b);

  always_comb begin
    alu_res = '0;
    case (aluop)
      2'b00: alu_res = sum;
      2'b01: alu_res = diff;
      2'b10: begin
        case (funct)
          F_ADD:   alu_res = sum;
          F_SUB:   alu_res = diff;
          F_AND:   alu_res = rdata1 & alu_b;
          F_OR:    alu_res = rdata1 | alu_b;
          F_SLT:   alu_res = {31'b0, slt_bit};
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the result sign flips.
  logic add_ovf, sub_ovf;
  assign add_ovf  = (rdata1[31] == alu_b[31]) && (sum[31]  != rdata1[31]);
  assign sub_ovf  = (rdata1[31] != alu_b[31]) && (diff[31] != rdata1[31]);
  assign ovf_trap = (aluop == 2'b10) &&
                    (((funct == F_ADD) && add_ovf) || ((funct == F_SUB) && sub_ovf));
`else
  assign ovf_trap = 1'b0;
`endif

  logic [1:0]  wb_q, wb_d;
  logic [2:0]  m_q, m_d;
  logic [31:0] add_q, add_d, alu_q, alu_d, r2_q, r2_d;
  logic        zero_q, zero_d, ovf_q, ovf_d;
  logic [4:0]  mux_q, mux_d;

  always_comb begin
    wb_d   = wb_q;
    m_d    = m_q;
    add_d  = add_q;
    zero_d = zero_q;
    alu_d  = alu_q;
    r2_d   = r2_q;
    mux_d  = mux_q;
    ovf_d  = ovf_q;
    if (!stall || flush) begin
      wb_d   = {ctlwb_in[1] & ~ovf_trap, ctlwb_in[0]};
      m_d    = ctlm_in;
      add_d  = npc + s_extendout;
      zero_d = (alu_res == 32'd0);
      alu_d  = alu_res;
      r2_d   = rdata2;
      mux_d  = regdst ? instr_1511 : instr_2016;
      ovf_d  = ovf_trap;
      // A bubble keeps the data path values but must not write back or touch memory.
      if (flush) begin
        wb_d  = '0;
        m_d   = '0;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q   <= '0;
      m_q    <= '0;
      add_q  <= '0;
      zero_q <= 1'b0;
      alu_q  <= '0;
      r2_q   <= '0;
      mux_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      add_q  <= add_d;
      zero_q <= zero_d;
      alu_q  <= alu_d;
      r2_q   <= r2_d;
      mux_q  <= mux_d;
      ovf_q  <= ovf_d;
    end
  end

  assign mem_ctlwb_out = wb_q;
  assign mem_ctlm_out  = m_q;
  assign add_result    = add_q;
  assign zero          = zero_q;
  assign alu_result    = alu_q;
  assign rdata2out     = r2_q;
  assign muxout        = mux_q;
  assign ovf           = ovf_q;

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; the block has one clock, and reset is synchronous and active-high.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  hold the EX/MEM latch; flush  in  1  insert a bubble.
REQ-004 SHALL have ports: ctlwb_in  in  2  {regwrite, memtoreg}; ctlm_in  in  3  {branch, memread, memwrite}.
REQ-005 SHALL have ports: regdst  in  1; aluop  in  2; alusrc  in  1.
REQ-006 SHALL have ports: npc  in  32; rdata1  in  32; rdata2  in  32; s_extendout  in  32; funct  in  6; instr_2016  in  5; instr_1511  in  5.
REQ-007 SHALL have ports: mem_ctlwb_out  out  2; mem_ctlm_out  out  3; add_result  out  32  branch target; zero  out  1; alu_result  out  32; rdata2out  out  32; muxout  out  5  destination register; ovf  out  1.

Function
REQ-008 SHALL compute combinationally: ALU B operand = alusrc ? s_extendout : rdata2.
REQ-009 SHALL decode ALU control as follows: aluop 00 -> add; aluop 01 -> sub; aluop 11 -> result 0.
REQ-010 SHALL decode ALU control for aluop 10 from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0); any other funct -> result 0.
REQ-011 SHALL perform all arithmetic modulo 2^32, and SHALL compute zero = (ALU result == 0).
REQ-012 SHALL compute add_result = npc + s_extendout, with no shift, because the PC is word-addressed.
REQ-013 SHALL select the destination register as regdst ? instr_1511 : instr_2016.
REQ-014 SHALL register every output in the EX/MEM latch on the rising edge of clk, giving one-cycle latency from inputs to outputs.
REQ-015 SHALL, when stall=1 and flush=0, keep all outputs at their current values.
REQ-016 SHALL, when flush=1, load mem_ctlwb_out=0, mem_ctlm_out=0 and ovf=0, and load the data outputs with the normally computed values.
REQ-017 SHALL apply the priority reset > flush > stall > normal capture.
REQ-018 SHALL pass rdata2 through to rdata2out unmodified, so that a store uses rt data regardless of alusrc.

Reset
REQ-019 SHALL, on a clk edge with reset=1, clear every output to 0.
REQ-020 SHALL let reset asserted mid-stall or mid-flush override both.
REQ-021 SHALL have its first capture on the first edge with reset=0.

Configuration
REQ-022 SHALL, with EX_OVF_TRAP_EN defined, detect signed overflow on add and sub, but only when aluop=10.
REQ-023 SHALL, on such an overflow, latch ovf=1, force mem_ctlwb_out[1] (regwrite) to 0, and still latch alu_result.
REQ-024 SHALL, with EX_OVF_TRAP_EN defined, never trap on aluop 00 or aluop 01.
REQ-025 SHALL, without EX_OVF_TRAP_EN, tie ovf to 0 and never modify the control bits.

Verification
REQ-026 SHALL cover: R-type add with rdata1=5, rdata2=4, aluop=10, funct=100000, regdst=1, instr_1511=2, ctlwb_in=10 -> after one edge alu_result=9, muxout=2, zero=0, mem_ctlwb_out=10.
REQ-027 SHALL cover: beq with rdata1=rdata2=7, aluop=01, npc=2, s_extendout=8, ctlm_in=100 -> zero=1, add_result=0xA, mem_ctlm_out=100.
REQ-028 SHALL cover: lw with rdata1=0x10, s_extendout=2, alusrc=1, aluop=00, regdst=0, instr_2016=2 -> alu_result=0x12, muxout=2, then sw with rdata2=0x64 -> rdata2out=0x64.
REQ-029 SHALL cover: stall=1 for 2 cycles while inputs change -> outputs unchanged; then flush=1 together with stall=1 -> control outputs 0.
REQ-030 SHALL cover: slt with rdata1=0xFFFFFFFF, rdata2=1 -> alu_result=1; an unsupported funct=000000 with aluop=10 -> alu_result=0, zero=1.
REQ-031 SHALL cover, with EX_OVF_TRAP_EN defined: add of 0x7FFFFFFF and 1 -> alu_result=0x80000000, ovf=1, mem_ctlwb_out[1]=0; without the macro -> ovf=0, regwrite preserved.
